// File: rtl/alu_pkg.sv
// Shared types, packet constants and the input-side CRC-4 for the ALU serial front end.
// Also used by the bench to build command packets.
package alu_pkg;

    typedef logic [10:0] packet_t;
    typedef logic [3:0]  in_crc_t;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CMD  = 1'b1;

    localparam int unsigned FrameBytes = 8;
    localparam logic [3:0]  CntFull    = 4'd8;
    localparam logic [3:0]  CntOver    = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StType,
        StPayload,
        StStop
    } rx_state_e;

    // Serial CRC-4 (x^4 + x + 1, init 0) over {a, b, 1'b1, op}, MSB first.
    function automatic in_crc_t calc_in_crc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [67:0] data;
        in_crc_t     crc;
        logic        fb;
        data = {a, b, 1'b1, op};
        crc  = '0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ data[i];
            crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return crc;
    endfunction

endpackage

// File: rtl/crc4_in.sv
// Combinational CRC-4 of the received operands and operation.
module crc4_in
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    output in_crc_t     crc_o
);

    assign crc_o = calc_in_crc(a_i, b_i, op_i);

endmodule

// File: rtl/alu_in_deserializer.sv
// Bit-level packet receiver and frame assembler: eight data bytes plus a command packet
// become A, B and op, checked for length, framing and CRC, reported with a one-cycle strobe.
module alu_in_deserializer
    import alu_pkg::*;
#(
    parameter logic IdleLevel = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sin_i,
    output logic        out_valid_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  op_o,
    output logic        err_data_o,
    output logic        err_crc_o
);

    rx_state_e   state_q, state_d;
    logic        type_q, type_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  data_cnt_q, data_cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    in_crc_t     rx_crc_q, rx_crc_d;
    logic        pend_q, pend_d;
    logic        pend_err_q, pend_err_d;
    logic        out_valid_q, out_valid_d;
    logic        err_data_q, err_data_d;
    logic        err_crc_q, err_crc_d;
    in_crc_t     calc_crc;

    crc4_in u_crc4_in (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .crc_o (calc_crc)
    );

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        data_cnt_d = data_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rx_crc_d   = rx_crc_q;
        pend_d     = 1'b0;
        pend_err_d = 1'b0;

        // Frame end is decided at the stop bit; the CRC is checked one cycle later, once
        // op has landed in its register, which puts the strobe at start edge + 11.
        out_valid_d = pend_q;
        err_data_d  = pend_q & pend_err_q;
        err_crc_d   = pend_q & ~pend_err_q & (rx_crc_q != calc_crc);

        unique case (state_q)
            StIdle: begin
                if (sin_i != IdleLevel) begin
                    state_d = StType;
                end
            end
            StType: begin
                type_d    = sin_i;
                bit_cnt_d = '0;
                state_d   = StPayload;
            end
            StPayload: begin
                shift_d   = {shift_q[6:0], sin_i};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                state_d = StIdle;
                if (!sin_i) begin
                    pend_d     = 1'b1;
                    pend_err_d = 1'b1;
                    data_cnt_d = '0;
                end else if (type_q == PKT_DATA) begin
                    // Slot k lands MSB-first: slots 0-3 fill A, slots 4-7 fill B.
                    if (data_cnt_q < 4'd4) begin
                        a_d[{~data_cnt_q[1:0], 3'b000} +: 8] = shift_q;
                    end else if (data_cnt_q < CntFull) begin
                        b_d[{~data_cnt_q[1:0], 3'b000} +: 8] = shift_q;
                    end
                    if (data_cnt_q != CntOver) begin
                        data_cnt_d = data_cnt_q + 4'd1;
                    end
                end else begin
                    op_d       = shift_q[6:4];
                    rx_crc_d   = shift_q[3:0];
                    pend_d     = 1'b1;
                    pend_err_d = (data_cnt_q != CntFull);
                    data_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            type_q      <= PKT_DATA;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_cnt_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rx_crc_q    <= '0;
            pend_q      <= 1'b0;
            pend_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_data_q  <= 1'b0;
            err_crc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_cnt_q  <= data_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rx_crc_q    <= rx_crc_d;
            pend_q      <= pend_d;
            pend_err_q  <= pend_err_d;
            out_valid_q <= out_valid_d;
            err_data_q  <= err_data_d;
            err_crc_q   <= err_crc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign err_data_o  = err_data_q;
    assign err_crc_o   = err_crc_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign op_o        = op_q;

endmodule
